// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two FIFO. Frame: start, DATA_BITS LSB first,
// optional parity, one or two stop bits. Framing config is captured when a byte is popped.
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_valid,
   input  logic [DATA_BITS-1:0]        wr_data,
   output logic                        wr_ready,
   input  logic [DIV_WIDTH-1:0]        baud_div,
   input  logic                        parity_en,
   input  logic                        parity_odd,
   input  logic                        stop2,
   input  logic                        ovf_clr,
   output logic                        uart_tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS-1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   // wr_valid/wr_ready: a byte transfers on every rising edge where both are high.
   // wr_ready comes only from registered occupancy, never from wr_valid or a same-cycle pop.
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic                 push, pop;
   logic [DATA_BITS-1:0] head;

   assign wr_ready = (fifo_count != FULL);
   assign push     = wr_valid && wr_ready;
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
         else if (pop && !push) fifo_count <= fifo_count - (AW+1)'(1);
         // a rejected write in the same cycle as a clear keeps the flag set
         if (wr_valid && !wr_ready) overflow <= 1'b1;
         else if (ovf_clr)          overflow <= 1'b0;
      end
   end

   state_t               state, state_n;
   logic [DIV_WIDTH-1:0] cnt, cnt_n, div_lat, div_n;
   logic [BW-1:0]        bit_idx, bit_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic                 par_en_lat, pen_n, par_bit, pbit_n, stop2_lat, s2_n;
   logic                 stop_second, stop_n, tx_n, bit_end;

   assign bit_end = (cnt == div_lat);
   assign busy    = (state != IDLE) || (fifo_count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         div_lat     <= '0;
         bit_idx     <= '0;
         sh          <= '0;
         par_en_lat  <= 1'b0;
         par_bit     <= 1'b0;
         stop2_lat   <= 1'b0;
         stop_second <= 1'b0;
         uart_tx     <= 1'b1;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         div_lat     <= div_n;
         bit_idx     <= bit_n;
         sh          <= sh_n;
         par_en_lat  <= pen_n;
         par_bit     <= pbit_n;
         stop2_lat   <= s2_n;
         stop_second <= stop_n;
         uart_tx     <= tx_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      div_n   = div_lat;
      bit_n   = bit_idx;
      sh_n    = sh;
      pen_n   = par_en_lat;
      pbit_n  = par_bit;
      s2_n    = stop2_lat;
      stop_n  = stop_second;
      tx_n    = uart_tx;
      pop     = 1'b0;
      if (state != IDLE) cnt_n = bit_end ? '0 : cnt + DIV_WIDTH'(1);
      case (state)
         IDLE: begin
            if (fifo_count != '0) begin
               pop     = 1'b1;
               state_n = START;
               tx_n    = 1'b0;
               cnt_n   = '0;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               bit_n   = '0;
               tx_n    = sh[0];
               sh_n    = sh >> 1;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_BIT) begin
                  if (par_en_lat) begin
                     state_n = PARITY;
                     tx_n    = par_bit;
                  end else begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                     stop_n  = 1'b0;
                  end
               end else begin
                  bit_n = bit_idx + BW'(1);
                  tx_n  = sh[0];
                  sh_n  = sh >> 1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_n = STOP;
               tx_n    = 1'b1;
               stop_n  = 1'b0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop2_lat && !stop_second) begin
                  stop_n = 1'b1;
               end else if (fifo_count != '0) begin
                  // back-to-back frames: next start bit follows the last stop bit directly
                  pop     = 1'b1;
                  state_n = START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (pop) begin
         sh_n   = head;
         div_n  = baud_div;
         pen_n  = parity_en;
         pbit_n = (^head) ^ parity_odd;
         s2_n   = stop2;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: line waveforms are compared cycle by cycle
// against hand-described frames queued in exp_q.
module tb_uart_tx_fifo;
  logic        clk, rst;
  logic        wr_valid, wr_ready, parity_en, parity_odd, stop2, ovf_clr;
  logic [7:0]  wr_data;
  logic [15:0] baud_div;
  logic        uart_tx, busy, overflow;
  logic [4:0]  fifo_count;
  logic        wr_valid5, wr_ready5, uart_tx5, busy5, overflow5;
  logic [4:0]  wr_data5;
  logic [4:0]  fifo_count5;

  logic [0:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_fifo dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .ovf_clr(ovf_clr), .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  uart_tx_fifo #(.DATA_BITS(5)) dut5 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid5), .wr_data(wr_data5), .wr_ready(wr_ready5),
    .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .ovf_clr(ovf_clr), .uart_tx(uart_tx5), .busy(busy5), .fifo_count(fifo_count5),
    .overflow(overflow5)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected line levels, one entry per clock cycle
  task automatic push_frame(input logic [7:0] d, input int nbits, input int div,
                            input bit pen, input bit pbit, input bit s2);
    for (int r = 0; r <= div; r++) exp_q.push_back(1'b0);
    for (int b = 0; b < nbits; b++)
      for (int r = 0; r <= div; r++) exp_q.push_back(d[b]);
    if (pen)
      for (int r = 0; r <= div; r++) exp_q.push_back(pbit);
    for (int s = 0; s < (s2 ? 2 : 1); s++)
      for (int r = 0; r <= div; r++) exp_q.push_back(1'b1);
  endtask

  task automatic expect_line(input int which, input int n, input string tag);
    logic e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check({tag, "_q_empty"}, 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d]", tag, i), (which != 0) ? uart_tx5 : uart_tx, e);
      end
    end
  endtask

  // one write, then confirm it is queued while the line is still idle
  task automatic send_one(input logic [7:0] d);
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    check("send_idle_line", uart_tx, 1);
    check("send_count", fifo_count, 1);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         odd;
    bit         pbit;
  } par_vec_t;

  par_vec_t par_tab[4] = '{
    '{8'h07, 1'b0, 1'b1},
    '{8'h07, 1'b1, 1'b0},
    '{8'h00, 1'b0, 1'b0},
    '{8'h00, 1'b1, 1'b1}
  };

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; wr_data = '0; baud_div = '0;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; ovf_clr = 1'b0;
    wr_valid5 = 1'b0; wr_data5 = '0;
    #1;
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // 8N1, divisor 3, 0x55: 40-cycle frame
    baud_div = 16'd3;
    push_frame(8'h55, 8, 3, 1'b0, 1'b0, 1'b0);
    send_one(8'h55);
    expect_line(0, 40, "f55");
    @(negedge clk);
    check("f55_busy_end", busy, 0);
    check("f55_line_end", uart_tx, 1);

    // parity, one cycle per bit
    baud_div  = 16'd0;
    parity_en = 1'b1;
    foreach (par_tab[k]) begin
      parity_odd = par_tab[k].odd;
      push_frame(par_tab[k].d, 8, 0, 1'b1, par_tab[k].pbit, 1'b0);
      send_one(par_tab[k].d);
      expect_line(0, 11, $sformatf("par%0d", k));
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;

    // fill the FIFO behind a slow frame, overflow handling, then gap-free drain
    baud_div = 16'd9;
    push_frame(8'hA5, 8, 9, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) push_frame(8'(i * 37 + 11), 8, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    @(posedge clk); #1;
    fork
      begin
        @(negedge clk);
        check("burst_idle_line", uart_tx, 1);
        expect_line(0, 100 + 160, "burst");
      end
      begin
        for (int i = 0; i < 16; i++) begin
          wr_data = 8'(i * 37 + 11);
          @(posedge clk); #1;
        end
        check("full_ready", wr_ready, 0);
        check("full_count", fifo_count, 16);
        check("ovf_before", overflow, 0);
        wr_data = 8'hEE;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        check("ovf_set", overflow, 1);
        check("drop_count", fifo_count, 16);
        wr_valid = 1'b1;
        wr_data  = 8'hEF;
        ovf_clr  = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        ovf_clr  = 1'b0;
        check("ovf_set_wins", overflow, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        check("clr_count", fifo_count, 16);
        baud_div = 16'd0;
      end
    join
    @(negedge clk);
    check("burst_busy_end", busy, 0);
    check("burst_count_end", fifo_count, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("burst_no_dropped", uart_tx, 1);
    end

    // 5 data bits, two stop bits, config toggled mid-frame
    baud_div = 16'd1;
    stop2    = 1'b1;
    push_frame(8'h1F, 5, 1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    wr_valid5 = 1'b1;
    wr_data5  = 5'h1F;
    @(posedge clk); #1;
    wr_valid5 = 1'b0;
    fork
      begin
        @(negedge clk);
        check("d5_idle_line", uart_tx5, 1);
        expect_line(1, 16, "d5");
        check("d5_busy_last_stop", busy5, 1);
      end
      begin
        repeat (6) @(negedge clk);
        stop2     = 1'b0;
        parity_en = 1'b1;
        baud_div  = 16'd0;
      end
    join
    @(negedge clk);
    check("d5_busy_end", busy5, 0);
    check("d5_line_end", uart_tx5, 1);
    check("d5_count", fifo_count5, 0);
    check("d5_ready", wr_ready5, 1);
    check("d5_ovf", overflow5, 0);
    parity_en = 1'b0;

    // reset during data bit 3 with four bytes queued
    baud_div = 16'd3;
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'h81;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("bit3_low", uart_tx, 0);
    check("bit3_count", fifo_count, 4);
    rst = 1'b1;
    #1;
    check("midrst_tx", uart_tx, 1);
    check("midrst_count", fifo_count, 0);
    check("midrst_ready", wr_ready, 1);
    check("midrst_ovf", overflow, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("postrst_line", uart_tx, 1);
    end
    check("postrst_busy", busy, 0);
    check("postrst_count", fifo_count, 0);

    // write on the first edge after reset release
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'hC3;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    check("first_write_count", fifo_count, 1);
    check("first_write_line", uart_tx, 1);
    push_frame(8'hC3, 8, 3, 1'b0, 1'b0, 1'b0);
    expect_line(0, 40, "fc3");
    @(negedge clk);
    check("fc3_busy_end", busy, 0);
    check("q_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
